// File: rtl/cla_pkg.sv
// cla_pkg: shared word width and sequencer state encoding for the CLA6 serial adder.
package cla_pkg;
    localparam int CLA_WORD_W = 6;
    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;
endpackage

// File: rtl/cla6.sv
// cla6: 6-bit carry-lookahead adder; every carry is a flat generate/propagate product term.
module cla6
    import cla_pkg::*;
(
    input  logic [CLA_WORD_W-1:0] a,
    input  logic [CLA_WORD_W-1:0] b,
    input  logic                  cin,
    output logic [CLA_WORD_W-1:0] so,
    output logic                  cout
);
    logic [CLA_WORD_W-1:0] g, p;
    logic [CLA_WORD_W:0]   c;
    logic                  pp;
    assign g = a & b;
    assign p = a ^ b;
    always_comb begin
        c = '0;
        pp = 1'b0;
        c[0] = cin;
        for (int i = 0; i < CLA_WORD_W; i++) begin
            c[i+1] = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin);
        end
    end
    assign so   = p ^ c[CLA_WORD_W-1:0];
    assign cout = c[CLA_WORD_W];
endmodule

// File: rtl/cla6_serial_wide_adder.sv
// cla6_serial_wide_adder: adds two NUM_WORDS*6-bit operands one 6-bit word per cycle through one cla6.
// Optional subtract port and a-b mode enabled by defining CLA6_SERIAL_SUB_EN.
module cla6_serial_wide_adder
    import cla_pkg::*;
#(
    parameter int NUM_WORDS = 4,
    localparam int W = CLA_WORD_W * NUM_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef CLA6_SERIAL_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    cla_seq_state_t        state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [W-1:0]          a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                  carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic                  do_sub, last;
    logic [CLA_WORD_W-1:0] a_w, b_w, so;
    logic                  co;

`ifdef CLA6_SERIAL_SUB_EN
    assign do_sub = sub;
`else
    assign do_sub = 1'b0;
`endif

    // b_q holds the effective operand (already inverted for subtract), so ovf uses it directly
    assign a_w  = a_q[idx_q*CLA_WORD_W +: CLA_WORD_W];
    assign b_w  = b_q[idx_q*CLA_WORD_W +: CLA_WORD_W];
    assign last = idx_q == IW'(NUM_WORDS - 1);

    cla6 u_cla6 (
        .a   (a_w),
        .b   (b_w),
        .cin (carry_q),
        .so  (so),
        .cout(co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            sum_d[idx_q*CLA_WORD_W +: CLA_WORD_W] = so;
            carry_d = co;
            idx_d   = idx_q + 1'b1;
            state_d = last ? DONE : RUN;
            cout_d  = last ? co : cout_q;
            ovf_d   = last ? ((a_w[CLA_WORD_W-1] == b_w[CLA_WORD_W-1]) && (so[CLA_WORD_W-1] != a_w[CLA_WORD_W-1])) : ovf_q;
        end else if (start) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = a;
            b_d     = do_sub ? ~b : b;
            carry_d = do_sub ? 1'b1 : cin;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla6_serial_wide_adder.sv
// tb_cla6_serial_wide_adder: directed vectors with hand-computed results for the 24-bit serial adder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cla6_serial_wide_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [23:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, ovf;
    logic [23:0] sum;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cla6_serial_wide_adder #(.NUM_WORDS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
`ifdef CLA6_SERIAL_SUB_EN
        .sub  (sub),
`endif
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one op and return at the falling edge where done must be high
    task automatic op(input string tag, input logic [23:0] ia, input logic [23:0] ib, input logic ic, input logic is);
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_busy_before_done"}, {30'd0, busy, done}, 32'b10);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, busy, done}, 32'b01);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {5'd0, busy, done, cout, ovf, sum}, 32'd0);
        rst = 1'b0;

        op("t2", 24'h000001, 24'hFFFFFF, 1'b0, 1'b0);
        chk("t2_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b1, 1'b0, 24'h000000});
        @(negedge clk);
        chk("t2_done_one_cycle", {31'd0, done}, 32'd0);

        op("t3", 24'h00003F, 24'h000001, 1'b0, 1'b0);
        chk("t3_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b0, 1'b0, 24'h000040});

        // Overflow op, an ignored start pulse in RUN, then start held into DONE
        @(negedge clk);
        a = 24'h7FFFFF; b = 24'h000001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 24'hABCDEF; b = 24'h123123; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 24'h123456; b = 24'h111111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b0, 1'b1, 24'h800000});
        @(negedge clk);
        start = 1'b0;
        chk("t4_b2b_accepted", {30'd0, busy, done}, 32'b10);
        repeat (3) @(negedge clk);
        chk("t4_b2b_not_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("t4_b2b_done", {31'd0, done}, 32'd1);
        chk("t4_b2b_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b0, 1'b0, 24'h234567});

        op("t5", 24'h000FC0, 24'h000040, 1'b1, 1'b0);
        chk("t5_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b0, 1'b0, 24'h001001});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold", {7'd0, cout, sum}, {7'd0, 1'b0, 24'h001001});
        end

        // Abort a run with async reset, starting from a nonzero held result
        op("t1_pre", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
        @(negedge clk);
        a = 24'hFFFFFF; b = 24'hFFFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("t1_async_clear", {5'd0, busy, done, cout, ovf, sum}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t1_no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end

`ifdef CLA6_SERIAL_SUB_EN
        op("t6a", 24'h000005, 24'h000007, 1'b0, 1'b1);
        chk("t6a_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b0, 1'b0, 24'hFFFFFE});
        op("t6b", 24'h800000, 24'h000001, 1'b0, 1'b1);
        chk("t6b_result", {6'd0, cout, ovf, sum}, {6'd0, 1'b1, 1'b1, 24'h7FFFFF});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
